// File: rtl/trace_input_arbiter.sv
// trace_input_arbiter
//   Picks one of NUM_REQ trace requesters per cycle and forwards its vector to
//   the debugger input buffer. Arbitration is round-robin between frames. Once
//   a frame's first vector is accepted, the arbiter locks onto that requester
//   until the frame ends (eof != 0). If the owner sits idle for LOCK_TIMEOUT
//   cycles, the lock is dropped.
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   req_vector     : NUM_REQ slices of N*DATA_WIDTH bits, slice i = requester i
//   req_valid      : per-requester valid
//   req_eof        : per-requester 2-bit eof code, nonzero marks the last vector
//   req_ready      : one-hot accept, combinational
//   stall          : debugger cannot accept; freezes the arbiter
//   vector_out     : registered vector of the last transfer
//   enqueue_out    : registered transfer strobe
//   eof_out        : registered eof code of the last transfer
//   grant_id       : registered index of the requester that made the last transfer
//   timeout_pulse  : one-cycle flag, a lock was dropped by timeout

// Per-lane output register. It loads on a transfer and holds otherwise.
module trace_input_arbiter_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

module trace_input_arbiter #(
  parameter int N            = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*N*DATA_WIDTH-1:0] req_vector,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*2-1:0]            req_eof,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            stall,
  output logic [N*DATA_WIDTH-1:0]         vector_out,
  output logic                            enqueue_out,
  output logic [1:0]                      eof_out,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            timeout_pulse
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int VW = N*DATA_WIDTH;
  localparam int CW = $clog2(LOCK_TIMEOUT+1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   idle_q, idle_d;
  logic            tp_d;

  logic [IW-1:0]   sel;
  logic            sel_ok;
  logic            xfer;
  logic [1:0]      sel_eof;
  logic [VW-1:0]   sel_vec;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ-1)) ? '0 : x + 1'b1;
  endfunction

  // Selection: the owner while locked. Otherwise the first valid requester
  // at or after ptr. The loop runs downward so that the nearest hit is the
  // last one written.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    if (state_q == LOCKED) begin
      sel    = owner_q;
      sel_ok = 1'b1;
    end else begin
      for (int j = NUM_REQ-1; j >= 0; j--) begin
        if (req_valid[(int'(ptr_q)+j) % NUM_REQ]) begin
          sel    = IW'((int'(ptr_q)+j) % NUM_REQ);
          sel_ok = 1'b1;
        end
      end
    end
  end

  assign xfer      = sel_ok & req_valid[sel] & ~stall & ~reset;
  assign sel_eof   = req_eof[sel*2 +: 2];
  assign sel_vec   = req_vector[sel*VW +: VW];
  assign req_ready = xfer ? (NUM_REQ'(1) << sel) : '0;

  // Next state. A stall holds everything. A transfer takes priority over a
  // timeout that would expire in the same cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    idle_d  = idle_q;
    tp_d    = 1'b0;
    if (!stall) begin
      if (xfer) begin
        idle_d = '0;
        if (sel_eof != 2'b00) begin
          state_d = UNLOCKED;
          ptr_d   = next_idx(sel);
        end else begin
          state_d = LOCKED;
          owner_d = sel;
        end
      end else if (state_q == LOCKED) begin
        if (idle_q == CW'(LOCK_TIMEOUT-1)) begin
          state_d = UNLOCKED;
          ptr_d   = next_idx(owner_q);
          idle_d  = '0;
          tp_d    = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= UNLOCKED;
      owner_q       <= '0;
      ptr_q         <= '0;
      idle_q        <= '0;
      enqueue_out   <= 1'b0;
      eof_out       <= 2'b00;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      idle_q        <= idle_d;
      enqueue_out   <= xfer;
      timeout_pulse <= tp_d;
      if (xfer) begin
        eof_out  <= sel_eof;
        grant_id <= sel;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    trace_input_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (xfer),
      .d     (sel_vec[k*DATA_WIDTH +: DATA_WIDTH]),
      .q     (vector_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_trace_input_arbiter.sv
module tb_trace_input_arbiter;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int VW = N*DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR*VW-1:0] req_vector;
  logic [NR-1:0]   req_valid;
  logic [NR*2-1:0] req_eof;
  logic [NR-1:0]   req_ready;
  logic            stall;
  logic [VW-1:0]   vector_out;
  logic            enqueue_out;
  logic [1:0]      eof_out;
  logic [1:0]      grant_id;
  logic            timeout_pulse;

  trace_input_arbiter #(.N(N), .DATA_WIDTH(DW), .NUM_REQ(NR), .LOCK_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req_vector(req_vector), .req_valid(req_valid),
    .req_eof(req_eof), .req_ready(req_ready), .stall(stall),
    .vector_out(vector_out), .enqueue_out(enqueue_out), .eof_out(eof_out),
    .grant_id(grant_id), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] eof;
    logic       stall;
    logic [3:0] rdy;
    logic       enq;
    logic [1:0] gid;
    logic [1:0] eofo;
  } vec_t;

  vec_t          tbl[19];
  int            n_vec = 0;
  int            n_bad = 0;
  int            seq = 0;
  logic [VW-1:0] exp_vec;

  function automatic logic [VW-1:0] mkdata(input int i, input int s);
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = 8'(i*64 + (s%16)*4 + k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s seq=%0d: got %0h, want %0h", name, seq, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational ready, clock,
  // then check the registered outputs.
  task automatic cyc(input logic [3:0] v, input logic [7:0] e, input logic st,
                     input logic [3:0] erdy, input logic eenq, input logic [1:0] egid,
                     input logic [1:0] eeof, input logic etp);
    seq++;
    req_valid = v;
    req_eof   = e;
    stall     = st;
    for (int i = 0; i < NR; i++) req_vector[i*VW +: VW] = mkdata(i, seq);
    #1;
    chk("req_ready", 64'(req_ready), 64'(erdy));
    if (eenq) exp_vec = mkdata(int'(egid), seq);
    @(posedge clk);
    #1;
    chk("enqueue_out", 64'(enqueue_out), 64'(eenq));
    chk("grant_id", 64'(grant_id), 64'(egid));
    chk("eof_out", 64'(eof_out), 64'(eeof));
    chk("timeout_pulse", 64'(timeout_pulse), 64'(etp));
    chk("vector_out", 64'(vector_out), 64'(exp_vec));
  endtask

  initial begin
    // Round robin with single-vector frames from every requester.
    tbl[0]  = '{4'hF, 8'h55, 1'b0, 4'h1, 1'b1, 2'd0, 2'd1};
    tbl[1]  = '{4'hF, 8'h55, 1'b0, 4'h2, 1'b1, 2'd1, 2'd1};
    tbl[2]  = '{4'hF, 8'h55, 1'b0, 4'h4, 1'b1, 2'd2, 2'd1};
    tbl[3]  = '{4'hF, 8'h55, 1'b0, 4'h8, 1'b1, 2'd3, 2'd1};
    tbl[4]  = '{4'hF, 8'h55, 1'b0, 4'h1, 1'b1, 2'd0, 2'd1};
    // ptr=1: req1 sends a one-vector frame, moving ptr to 2.
    tbl[5]  = '{4'h2, 8'h04, 1'b0, 4'h2, 1'b1, 2'd1, 2'd1};
    // ptr=2: search 2,3,0 finds req0. It sends a 3-vector frame while req1 waits.
    tbl[6]  = '{4'h3, 8'h04, 1'b0, 4'h1, 1'b1, 2'd0, 2'd0};
    tbl[7]  = '{4'h3, 8'h04, 1'b0, 4'h1, 1'b1, 2'd0, 2'd0};
    tbl[8]  = '{4'h3, 8'h07, 1'b0, 4'h1, 1'b1, 2'd0, 2'd3};
    tbl[9]  = '{4'h3, 8'h04, 1'b0, 4'h2, 1'b1, 2'd1, 2'd1};
    // Idle cycle: outputs hold.
    tbl[10] = '{4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 2'd1, 2'd1};
    // ptr=2: req2 locks, then a 5-cycle stall, then it resumes and ends the frame with eof=2.
    tbl[11] = '{4'h4, 8'h00, 1'b0, 4'h4, 1'b1, 2'd2, 2'd0};
    tbl[12] = '{4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 2'd2, 2'd0};
    tbl[13] = '{4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 2'd2, 2'd0};
    tbl[14] = '{4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 2'd2, 2'd0};
    tbl[15] = '{4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 2'd2, 2'd0};
    tbl[16] = '{4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 2'd2, 2'd0};
    tbl[17] = '{4'hF, 8'h00, 1'b0, 4'h4, 1'b1, 2'd2, 2'd0};
    tbl[18] = '{4'hF, 8'h20, 1'b0, 4'h4, 1'b1, 2'd2, 2'd2};

    // Reset with every requester valid: nothing may be accepted.
    reset = 1'b1; stall = 1'b0; req_valid = 4'hF; req_eof = 8'h55; req_vector = '0;
    exp_vec = '0;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_enqueue", 64'(enqueue_out), 64'h0);
    chk("rst_grant", 64'(grant_id), 64'h0);
    chk("rst_eof", 64'(eof_out), 64'h0);
    chk("rst_tp", 64'(timeout_pulse), 64'h0);
    chk("rst_vector", 64'(vector_out), 64'h0);
    reset = 1'b0;

    for (int r = 0; r < 19; r++)
      cyc(tbl[r].valid, tbl[r].eof, tbl[r].stall, tbl[r].rdy, tbl[r].enq, tbl[r].gid, tbl[r].eofo, 1'b0);

    // ptr=3: req2 locks, then goes idle while req3 waits. The timeout fires on
    // the 64th idle cycle, and req3 wins the next cycle.
    cyc(4'h4, 8'h00, 1'b0, 4'h4, 1'b1, 2'd2, 2'd0, 1'b0);
    for (int k = 1; k <= 64; k++)
      cyc(4'h8, 8'h00, 1'b0, 4'h0, 1'b0, 2'd2, 2'd0, k == 64);
    cyc(4'h8, 8'h40, 1'b0, 4'h8, 1'b1, 2'd3, 2'd1, 1'b0);

    // ptr=0: lock req1, then reset mid-frame.
    cyc(4'h2, 8'h00, 1'b0, 4'h2, 1'b1, 2'd1, 2'd0, 1'b0);
    reset = 1'b1;
    exp_vec = '0;
    cyc(4'hF, 8'h55, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b0;
    cyc(4'hF, 8'h55, 1'b0, 4'h1, 1'b1, 2'd0, 2'd1, 1'b0);
    cyc(4'hF, 8'h55, 1'b0, 4'h2, 1'b1, 2'd1, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/trace_input_arbiter.md
TRACE_INPUT_ARBITER -- requirements
Module: trace_input_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N, 16, lanes per vector
- DATA_WIDTH, 32, bits per lane
- NUM_REQ, 4, requester count, 2..8
- LOCK_TIMEOUT, 64, idle cycles before a frame lock is forcibly dropped, >=2
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, all logic on posedge
- reset, in, 1, synchronous, active-high
- req_vector, in, NUM_REQ*N*DATA_WIDTH, requester i occupies slice i, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH] within slice
- req_valid, in, NUM_REQ, requester i presents a vector
- req_eof, in, NUM_REQ*2, per-requester eof code; nonzero = last vector of frame
- req_ready, out, NUM_REQ, vector of requester i accepted this cycle
- stall, in, 1, debugger input buffer cannot accept
- vector_out, out, N*DATA_WIDTH, registered vector to debugger vector_in
- enqueue_out, out, 1, registered enqueue strobe to debugger
- eof_out, out, 2, registered eof code to debugger eof_in
- grant_id, out, $clog2(NUM_REQ), requester that produced current output
- timeout_pulse, out, 1, one-cycle flag: lock dropped by timeout

Function
REQ-003 State SHALL be UNLOCKED or LOCKED(owner), plus round-robin pointer ptr and idle counter.
REQ-004 In UNLOCKED, sel SHALL be the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ; none valid -> no selection.
REQ-005 In LOCKED, sel SHALL be owner regardless of other requesters' req_valid.
REQ-006 req_ready[i] SHALL be 1 only when stall=0, reset=0, a selection exists, i=sel and req_valid[sel]=1; at most one bit set; combinational from current state/inputs.
REQ-007 Transfer occurs when req_valid[sel]&req_ready[sel]; next cycle vector_out, eof_out, grant_id SHALL hold sel's data, eof, index and enqueue_out SHALL be 1 (latency 1 cycle).
REQ-008 In any cycle without a transfer, enqueue_out SHALL be 0 next cycle; vector_out, eof_out, grant_id SHALL hold.
REQ-009 On a transfer with eof=0, state SHALL become LOCKED(sel).
REQ-010 On a transfer with eof!=0, state SHALL become UNLOCKED and ptr SHALL become (sel+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
REQ-011 One-vector frames (eof!=0 on first vector) SHALL never lock.
REQ-012 Idle counter SHALL clear on every transfer and on entry to LOCKED; increment each LOCKED cycle with req_valid[owner]=0 and stall=0; hold while stall=1.
REQ-013 When idle counter reaches LOCK_TIMEOUT-1 and increments, state SHALL become UNLOCKED, ptr=(owner+1) mod NUM_REQ, timeout_pulse=1 for exactly one cycle; otherwise timeout_pulse=0.
REQ-014 If timeout and owner's req_valid assert in the same cycle, the transfer SHALL win and no timeout occurs.
REQ-015 stall=1 SHALL freeze state, ptr and outputs except enqueue_out, which is 0.
REQ-016 Requester data SHALL pass unmodified; no arithmetic on lanes.

Reset
REQ-017 reset=1 at a clock edge SHALL force UNLOCKED, ptr=0, idle counter=0, vector_out=0, eof_out=0, grant_id=0, enqueue_out=0, timeout_pulse=0, and all req_ready=0 that cycle, including mid-frame; partial frames are abandoned.

Verification
REQ-018 Bench SHALL cover: NUM_REQ=4, all req_valid=1, every vector eof=1 -> grant_id sequence 0,1,2,3,0, enqueue_out=1 every cycle.
REQ-019 Bench SHALL cover: req0 sends 3-vector frame (eof 0,0,1) while req1 valid throughout -> grant_id 0,0,0 then 1; req_ready[1]=0 during frame.
REQ-020 Bench SHALL cover: req2 sends eof=0 then drops valid, LOCK_TIMEOUT=64 -> timeout_pulse=1 on 64th idle cycle, then req3 granted.
REQ-021 Bench SHALL cover: stall=1 for 5 cycles mid-frame -> req_ready=0, enqueue_out=0, vector_out unchanged; resumes with same owner.
REQ-022 Bench SHALL cover: reset pulse while LOCKED(1) -> next cycle all outputs 0, then req0 granted first with all valid.
